// File: rtl/st_irq_ack_ctrl.sv
// rtl/st_irq_ack_ctrl.sv - 68000 IPL merge and interrupt-acknowledge sequencer for MFP/VBL/HBL
// Optional macro IACK_TIMEOUT_EN: spurious-vector response when the MFP never answers an iack.
module st_irq_ack_ctrl #(
  parameter int         TIMEOUT_TICKS = 32,
  parameter logic [7:0] SPURIOUS_VEC  = 8'h18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       hbl,
  input  logic       vbl,
  input  logic       mfp_irq,
  input  logic       cpu_iack,
  input  logic [2:0] cpu_level,
  output logic [2:0] ipl_n,
  output logic [7:0] cpu_dout,
  output logic       cpu_dtack,
  output logic       cpu_vpa,
  output logic       mfp_iack,
  output logic       mfp_ds,
  input  logic       mfp_dtack,
  input  logic [7:0] mfp_dout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MFP_REQ  = 3'd1;
  localparam logic [2:0] S_MFP_WAIT = 3'd2;
  localparam logic [2:0] S_MFP_DONE = 3'd3;
  localparam logic [2:0] S_AUTO     = 3'd4;

  logic [2:0] state;
  logic       hbl_d, vbl_d, iack_d;
  logic       hbl_p, vbl_p;
  logic       iack_rise, clr_h, clr_v;
  logic [2:0] level;

  assign iack_rise = cpu_iack & ~iack_d;

  // Autovector levels clear their pending flag on the acknowledge entry tick only.
  always_comb begin
    clr_v = 1'b0;
    clr_h = 1'b0;
    if (state == S_IDLE && iack_rise) begin
      clr_v = (cpu_level == 3'd4);
      clr_h = (cpu_level == 3'd2);
    end
  end

  always_comb begin
    level = 3'd0;
    if (mfp_irq)    level = 3'd6;
    else if (vbl_p) level = 3'd4;
    else if (hbl_p) level = 3'd2;
  end

`ifdef IACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
  logic [CNT_W-1:0] cnt;
`else
  wire [39:0] unused_cfg = {SPURIOUS_VEC, 32'(TIMEOUT_TICKS)};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hbl_d     <= 1'b0;
      vbl_d     <= 1'b0;
      iack_d    <= 1'b0;
      hbl_p     <= 1'b0;
      vbl_p     <= 1'b0;
      ipl_n     <= 3'b111;
      cpu_dout  <= 8'h00;
      cpu_dtack <= 1'b0;
      cpu_vpa   <= 1'b0;
      mfp_iack  <= 1'b0;
      mfp_ds    <= 1'b1;
`ifdef IACK_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else if (clk_en) begin
      hbl_d  <= hbl;
      vbl_d  <= vbl;
      iack_d <= cpu_iack;
      // A fresh edge wins over a clear in the same tick so it is never lost.
      hbl_p  <= (hbl & ~hbl_d) | (hbl_p & ~clr_h);
      vbl_p  <= (vbl & ~vbl_d) | (vbl_p & ~clr_v);
      ipl_n  <= ~level;

      case (state)
        S_IDLE: begin
          if (iack_rise) begin
            if (cpu_level == 3'd6) begin
              state <= S_MFP_REQ;
            end else begin
              state   <= S_AUTO;
              cpu_vpa <= 1'b1;
            end
          end
        end
        S_MFP_REQ: begin
          if (!cpu_iack) begin
            state <= S_IDLE;
          end else begin
            mfp_iack <= 1'b1;
            mfp_ds   <= 1'b0;
            state    <= S_MFP_WAIT;
`ifdef IACK_TIMEOUT_EN
            cnt      <= '0;
`endif
          end
        end
        S_MFP_WAIT: begin
          if (!cpu_iack) begin
            mfp_iack <= 1'b0;
            mfp_ds   <= 1'b1;
            state    <= S_IDLE;
          end else if (mfp_dtack) begin
            cpu_dout  <= mfp_dout;
            cpu_dtack <= 1'b1;
            state     <= S_MFP_DONE;
          end
`ifdef IACK_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
            cpu_dout  <= SPURIOUS_VEC;
            cpu_dtack <= 1'b1;
            mfp_iack  <= 1'b0;
            mfp_ds    <= 1'b1;
            state     <= S_MFP_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_MFP_DONE: begin
          if (!cpu_iack) begin
            cpu_dtack <= 1'b0;
            mfp_iack  <= 1'b0;
            mfp_ds    <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_AUTO: begin
          if (!cpu_iack) begin
            cpu_vpa <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_st_irq_ack_ctrl.sv
// tb/tb_st_irq_ack_ctrl.sv - directed scoreboard bench for st_irq_ack_ctrl
module tb_st_irq_ack_ctrl;

  logic       clk = 1'b0;
  logic       reset, clk_en, hbl, vbl, mfp_irq, cpu_iack, mfp_dtack;
  logic [2:0] cpu_level;
  logic [7:0] mfp_dout;
  logic [2:0] ipl_n;
  logic [7:0] cpu_dout;
  logic       cpu_dtack, cpu_vpa, mfp_iack, mfp_ds;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  st_irq_ack_ctrl #(.TIMEOUT_TICKS(4), .SPURIOUS_VEC(8'h18)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .hbl(hbl), .vbl(vbl),
    .mfp_irq(mfp_irq), .cpu_iack(cpu_iack), .cpu_level(cpu_level),
    .ipl_n(ipl_n), .cpu_dout(cpu_dout), .cpu_dtack(cpu_dtack), .cpu_vpa(cpu_vpa),
    .mfp_iack(mfp_iack), .mfp_ds(mfp_ds), .mfp_dtack(mfp_dtack), .mfp_dout(mfp_dout)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [7:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
      return;
    end
    e = sb.pop_front();
    total++;
    assert (obs === e.exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic ack(input logic [2:0] lvl);
    cpu_level = lvl;
    cpu_iack  = 1'b1;
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; hbl = 1'b0; vbl = 1'b0; mfp_irq = 1'b0;
    cpu_iack = 1'b0; cpu_level = 3'd0; mfp_dtack = 1'b0; mfp_dout = 8'h00;
    tick(2);
    reset = 1'b0;

    push("rst_ipl_n", 8'h07);     pop_chk({5'd0, ipl_n});
    push("rst_mfp_ds", 8'h01);    pop_chk({7'd0, mfp_ds});
    push("rst_mfp_iack", 8'h00);  pop_chk({7'd0, mfp_iack});
    push("rst_dtack", 8'h00);     pop_chk({7'd0, cpu_dtack});
    push("rst_vpa", 8'h00);       pop_chk({7'd0, cpu_vpa});
    push("rst_dout", 8'h00);      pop_chk(cpu_dout);

    // VBL edge, then autovector acknowledge at level 4
    vbl = 1'b1;
    push("vbl_ipl_early", 8'h07); tick(); pop_chk({5'd0, ipl_n});
    push("vbl_ipl", 8'h03);       tick(); pop_chk({5'd0, ipl_n});
    vbl = 1'b0;
    ack(3'd4);
    push("l4_vpa", 8'h01);        tick(); pop_chk({7'd0, cpu_vpa});
    push("l4_no_dtack", 8'h00);   pop_chk({7'd0, cpu_dtack});
    push("l4_ipl_cleared", 8'h07); tick(); pop_chk({5'd0, ipl_n});
    cpu_iack = 1'b0;
    push("l4_vpa_off", 8'h00);    tick(); pop_chk({7'd0, cpu_vpa});

    // clk_en low freezes edge detection and IPL
    clk_en = 1'b0; vbl = 1'b1;
    push("en_low_ipl", 8'h07);    tick(2); pop_chk({5'd0, ipl_n});
    vbl = 1'b0;
    push("en_low_ipl2", 8'h07);   tick(); pop_chk({5'd0, ipl_n});
    clk_en = 1'b1;
    tick();

    // Both blanks plus MFP irq, level 6 acknowledge via MFP
    hbl = 1'b1; vbl = 1'b1; mfp_irq = 1'b1;
    tick();
    hbl = 1'b0; vbl = 1'b0;
    push("mfp_ipl", 8'h01);       tick(); pop_chk({5'd0, ipl_n});
    ack(3'd6);
    push("l6_req_iack", 8'h00);   tick(); pop_chk({7'd0, mfp_iack});
    push("l6_mfp_iack", 8'h01);   tick(); pop_chk({7'd0, mfp_iack});
    push("l6_mfp_ds", 8'h00);     pop_chk({7'd0, mfp_ds});
    push("l6_dtack_early", 8'h00); pop_chk({7'd0, cpu_dtack});
    mfp_dtack = 1'b1; mfp_dout = 8'h4D;
    push("l6_dtack", 8'h01);      tick(); pop_chk({7'd0, cpu_dtack});
    push("l6_vector", 8'h4D);     pop_chk(cpu_dout);
    mfp_dtack = 1'b0; mfp_dout = 8'h00;
    push("l6_dtack_hold", 8'h01); tick(); pop_chk({7'd0, cpu_dtack});
    push("l6_no_vpa", 8'h00);     pop_chk({7'd0, cpu_vpa});
    push("l6_flags_kept", 8'h01); pop_chk({5'd0, ipl_n});
    cpu_iack = 1'b0; mfp_irq = 1'b0;
    push("l6_release_dtack", 8'h00); tick(); pop_chk({7'd0, cpu_dtack});
    push("l6_release_iack", 8'h00);  pop_chk({7'd0, mfp_iack});
    push("l6_release_ds", 8'h01);    pop_chk({7'd0, mfp_ds});
    push("both_ipl", 8'h03);      tick(); pop_chk({5'd0, ipl_n});

    // Ack 4 leaves HBL, ack 2 clears it; HBL edge inside AUTO stays pending
    ack(3'd4); tick(2);
    push("after_l4_ipl", 8'h05);  pop_chk({5'd0, ipl_n});
    cpu_iack = 1'b0; tick();
    ack(3'd2); tick();
    hbl = 1'b1; tick();
    hbl = 1'b0;
    push("hbl_repend_ipl", 8'h05); tick(); pop_chk({5'd0, ipl_n});
    cpu_iack = 1'b0; tick();
    ack(3'd2); tick(2);
    push("after_l2_ipl", 8'h07);  pop_chk({5'd0, ipl_n});
    cpu_iack = 1'b0; tick();

    // Reset during MFP_WAIT
    mfp_irq = 1'b1; ack(3'd6); tick(3);
    push("w_mfp_iack", 8'h01);    pop_chk({7'd0, mfp_iack});
    reset = 1'b1;
    tick();
    push("wrst_mfp_iack", 8'h00); pop_chk({7'd0, mfp_iack});
    push("wrst_mfp_ds", 8'h01);   pop_chk({7'd0, mfp_ds});
    push("wrst_dtack", 8'h00);    pop_chk({7'd0, cpu_dtack});
    push("wrst_ipl", 8'h07);      pop_chk({5'd0, ipl_n});
    reset = 1'b0; cpu_iack = 1'b0; mfp_irq = 1'b0;
    tick();

    // Aborted acknowledge, late MFP answer must not produce dtack
    ack(3'd6); tick(3);
    cpu_iack = 1'b0;
    push("abort_mfp_iack", 8'h00); tick(); pop_chk({7'd0, mfp_iack});
    push("abort_mfp_ds", 8'h01);   pop_chk({7'd0, mfp_ds});
    mfp_dtack = 1'b1; mfp_dout = 8'h77;
    for (int i = 0; i < 3; i++) begin
      push("abort_no_dtack", 8'h00); tick(); pop_chk({7'd0, cpu_dtack});
    end
    mfp_dtack = 1'b0;
    tick();

    // MFP never responds
    ack(3'd6); tick(2);
`ifdef IACK_TIMEOUT_EN
    push("to_wait3", 8'h00);      tick(3); pop_chk({7'd0, cpu_dtack});
    push("to_dtack", 8'h01);      tick(); pop_chk({7'd0, cpu_dtack});
    push("to_vector", 8'h18);     pop_chk(cpu_dout);
    push("to_mfp_iack", 8'h00);   pop_chk({7'd0, mfp_iack});
`else
    push("nto_dtack", 8'h00);     tick(100); pop_chk({7'd0, cpu_dtack});
    push("nto_mfp_iack", 8'h01);  pop_chk({7'd0, mfp_iack});
    push("nto_mfp_ds", 8'h00);    pop_chk({7'd0, mfp_ds});
`endif
    cpu_iack = 1'b0;
    push("end_idle_dtack", 8'h00); tick(); pop_chk({7'd0, cpu_dtack});
    push("end_idle_iack", 8'h00);  pop_chk({7'd0, mfp_iack});

    if (sb.size() != 0) begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // dtack and vpa are mutually exclusive at all times outside reset
  always @(negedge clk) begin
    if (!reset && cpu_dtack && cpu_vpa) begin
      bad++;
      $error("FAIL dtack_vpa_excl observed=11 expected=not_both");
    end
  end

endmodule

// File: doc/st_irq_ack_ctrl.md
Name: st_irq_ack_ctrl

Overview:
- CPU-side counterpart of the MFP interrupt interface, in the glue-logic area between the 68000 core and the MFP.
- Merges the MFP irq (level 6), VBL (level 4) and HBL (level 2) into the CPU IPL lines.
- Runs 68000 interrupt-acknowledge cycles: level 6 drives the MFP iack/ds handshake and returns the MFP's vector with DTACK; levels 4/2 answer with VPA (autovector).

Parameters:
- TIMEOUT_TICKS, 32, clk_en ticks to wait for MFP dtack before a spurious-interrupt response (used only with IACK_TIMEOUT_EN).
- SPURIOUS_VEC, 8'h18, vector returned on timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- clk_en  in  1  bus-rate enable; all state advances only when high
- hbl  in  1  horizontal blank, rising edge sets HBL pending
- vbl  in  1  vertical blank, rising edge sets VBL pending
- mfp_irq  in  1  MFP interrupt request, level, active-high
- cpu_iack  in  1  CPU interrupt-acknowledge cycle active (FC=7 and AS)
- cpu_level  in  3  acknowledged level (A3..A1)
- ipl_n  out  3  encoded IPL to CPU, active-low
- cpu_dout  out  8  vector byte to CPU
- cpu_dtack  out  1  vector valid / cycle terminate
- cpu_vpa  out  1  autovector request
- mfp_iack  out  1  to MFP iack
- mfp_ds  out  1  to MFP ds, active-low
- mfp_dtack  in  1  MFP dtack
- mfp_dout  in  8  MFP data bus (vector during iack)

Behaviour:
- Reset (synchronous, takes priority over clk_en): ipl_n=3'b111, cpu_dout=0, cpu_dtack=0, cpu_vpa=0, mfp_iack=0, mfp_ds=1, pending flags cleared, edge registers cleared, state IDLE, timeout counter 0.
- Edge detect on clk_en: hbl_p set when hbl&~hblD; vbl_p set when vbl&~vblD.
  - Set wins over a same-tick clear.
- IPL, registered on clk_en: mfp_irq -> 6, else vbl_p -> 4, else hbl_p -> 2, else 0. ipl_n = ~level.
  - IPL is one tick late relative to its inputs.
- FSM, advancing on clk_en only:
  - IDLE: when cpu_iack rises:
    - level 6 -> MFP_REQ.
    - level 4 or 2 -> AUTO.
    - any other level -> AUTO without clearing any flag.
  - MFP_REQ: mfp_iack=1, mfp_ds=0; clear counter; -> MFP_WAIT.
  - MFP_WAIT: hold mfp_iack/mfp_ds.
    - When mfp_dtack=1: latch mfp_dout into cpu_dout; -> MFP_DONE.
  - MFP_DONE: cpu_dtack=1. Hold until cpu_iack=0, then deassert mfp_iack, set mfp_ds=1, cpu_dtack=0; -> IDLE.
  - AUTO: cpu_vpa=1.
    - Level 4: clear vbl_p in the entry tick.
    - Level 2: clear hbl_p in the entry tick.
    - Hold cpu_vpa until cpu_iack=0, then cpu_vpa=0; -> IDLE.
- cpu_iack dropping in MFP_REQ or MFP_WAIT (aborted cycle): deassert mfp_iack, set mfp_ds=1; -> IDLE; no dtack is issued.
- A new edge on hbl/vbl during AUTO for the same level after the clear is kept pending.
- cpu_dtack and cpu_vpa are never both 1.
- Latency: cpu_dtack at the earliest 3 ticks after cpu_iack rises, with MFP dtack on the first wait tick. cpu_vpa 1 tick after cpu_iack rises.

Optional Feature:
- Macro IACK_TIMEOUT_EN.
- When defined:
  - MFP_WAIT counts clk_en ticks.
  - On reaching TIMEOUT_TICKS without mfp_dtack: cpu_dout=SPURIOUS_VEC, deassert mfp_iack/mfp_ds, -> MFP_DONE (cpu_dtack=1).
- When undefined: MFP_WAIT waits indefinitely; no counter logic is present.

Test Plan:
- Reset, then vbl pulse -> ipl_n=3'b011 one tick after the edge. cpu_iack with level 4 -> cpu_vpa=1 next tick, vbl_p cleared; release cpu_iack -> cpu_vpa=0, ipl_n=3'b111.
- mfp_irq=1 with hbl_p and vbl_p set -> ipl_n=3'b001. cpu_iack level 6 -> mfp_iack=1, mfp_ds=0; MFP answers mfp_dtack with mfp_dout=8'h4D -> cpu_dout=8'h4D, cpu_dtack=1; pending flags untouched.
- hbl and vbl edges in the same tick -> ipl_n=3'b011. Ack level 4 -> ipl_n=3'b101. Ack level 2 -> ipl_n=3'b111.
- Assert reset during MFP_WAIT -> next clk: mfp_iack=0, mfp_ds=1, cpu_dtack=0, state IDLE, ipl_n=3'b111.
- cpu_iack dropped during MFP_WAIT -> mfp_iack=0 next tick, cpu_dtack never asserted.
- IACK_TIMEOUT_EN defined, TIMEOUT_TICKS=4, MFP never responds -> cpu_dtack=1 with cpu_dout=8'h18 after 4 wait ticks. Undefined: still waiting after 100 ticks.
